// File: rtl/retire_perf_monitor_if.sv
// rtl/retire_perf_monitor_if.sv - counter readout request/acknowledge port
//
// Purpose: groups the single-outstanding readout handshake of the retire
// performance monitor.
// Ports (signals):
//   rd_req   requester -> monitor  level request, held until rd_ack is seen
//   rd_sel   requester -> monitor  counter index, sampled with rd_req
//   rd_ack   monitor -> requester  one-cycle pulse, rd_data valid
//   rd_data  monitor -> requester  counter snapshot, held until next ack
// Modports: master = requester side, slave = monitor side.

interface retire_perf_monitor_if #(
  parameter int CNT_W = 32
) ();
  logic             rd_req;
  logic [2:0]       rd_sel;
  logic             rd_ack;
  logic [CNT_W-1:0] rd_data;

  modport master (output rd_req, output rd_sel, input rd_ack, input rd_data);
  modport slave  (input rd_req, input rd_sel, output rd_ack, output rd_data);
endinterface

// File: rtl/retire_perf_monitor.sv
// rtl/retire_perf_monitor.sv - saturating retire-side event counters with readout
//
// Purpose: counts cycles, retired instructions, I/D cache requests and hits,
// stamps the cycle count at halt, and counts cache protocol errors. Counting
// freezes while halted until clear. Counters are read one at a time through
// a request/acknowledge port.
// Ports:
//   clk              system clock, rising edge
//   rst              synchronous active-low reset
//   retire_regwrite  register-file write commits this cycle
//   retire_memwrite  data-memory write commits this cycle
//   halt             halt instruction in memory/writeback this cycle
//   icache_req/hit   instruction-cache request / hit this cycle
//   dcache_req/hit   data-cache request / hit this cycle
//   clear            zero all counters, return to RUN
//   rd               readout port (slave modport)
//   halted           monitor is in HALTED
// Counter map: 0 cycles, 1 instructions, 2 icache_req, 3 icache_hit,
//   4 dcache_req, 5 dcache_hit, 6 cycle stamp at halt, 7 protocol errors.

module retire_perf_monitor #(
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 retire_regwrite,
  input  logic                 retire_memwrite,
  input  logic                 halt,
  input  logic                 icache_req,
  input  logic                 icache_hit,
  input  logic                 dcache_req,
  input  logic                 dcache_hit,
  input  logic                 clear,
  retire_perf_monitor_if.slave rd,
  output logic                 halted
);
  typedef enum logic {RUN, HALTED} run_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ACK, R_WAIT} rd_state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam int SEL_STAMP = 6;

  run_state_t       run_state;
  run_state_t       run_state_nxt;
  rd_state_t        rd_state;
  rd_state_t        rd_state_nxt;
  logic [CNT_W-1:0] cnt     [8];
  logic [CNT_W-1:0] cnt_nxt [8];
  logic [CNT_W-1:0] cyc_inc;
  logic [7:0]       ev;
  logic             counting;
  logic             rd_load;
  logic [CNT_W-1:0] rd_data_q;

  // Counter next-state and run/halt FSM next-state.
  always_comb begin
    counting      = (run_state == RUN);
    run_state_nxt = run_state;

    ev    = 8'b0;
    ev[0] = 1'b1;
    ev[1] = halt | retire_regwrite | retire_memwrite;
    ev[2] = icache_req;
    ev[3] = icache_hit;
    ev[4] = dcache_req;
    ev[5] = dcache_hit;
    // ev[6] stays 0: the halt stamp is loaded, never incremented
    ev[7] = (icache_hit & ~icache_req) | (dcache_hit & ~dcache_req);

    cyc_inc = (cnt[0] != CNT_MAX) ? cnt[0] + CNT_W'(1) : cnt[0];

    for (int i = 0; i < 8; i++) begin
      cnt_nxt[i] = cnt[i];
      if (counting && ev[i] && (cnt[i] != CNT_MAX)) begin
        cnt_nxt[i] = cnt[i] + CNT_W'(1);
      end
    end

    // The halt edge still counts; the stamp takes the post-increment cycle count
    if (counting && halt) begin
      cnt_nxt[SEL_STAMP] = cyc_inc;
      run_state_nxt      = HALTED;
    end

    // clear beats halt and any same-edge events
    if (clear) begin
      for (int i = 0; i < 8; i++) begin
        cnt_nxt[i] = '0;
      end
      run_state_nxt = RUN;
    end
  end

  // Readout FSM next-state; a held rd_req yields a single ack via R_WAIT.
  always_comb begin
    rd_state_nxt = rd_state;
    rd_load      = 1'b0;
    case (rd_state)
      R_IDLE: begin
        if (rd.rd_req) begin
          rd_state_nxt = R_ACK;
          rd_load      = 1'b1;
        end
      end
      R_ACK:   rd_state_nxt = R_WAIT;
      R_WAIT: begin
        if (!rd.rd_req) begin
          rd_state_nxt = R_IDLE;
        end
      end
      default: rd_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      run_state <= RUN;
      rd_state  <= R_IDLE;
    end else begin
      run_state <= run_state_nxt;
      rd_state  <= rd_state_nxt;
    end
  end

  // Snapshot uses the next counter value so the request edge's own update is seen.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_data_q <= '0;
      for (int i = 0; i < 8; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
      if (rd_load) begin
        rd_data_q <= cnt_nxt[rd.rd_sel];
      end
    end
  end

  assign rd.rd_ack  = (rd_state == R_ACK);
  assign rd.rd_data = rd_data_q;
  assign halted     = (run_state == HALTED);

endmodule

// File: doc/retire_perf_monitor.md
# retire_perf_monitor

Synthesizable retire-side event monitor that sits directly downstream of the pipeline's writeback/memory commit point. It consumes the same per-cycle commit signals the simulation trace bench samples (register write, memory write, halt, I/D cache request/hit) and keeps saturating hardware counters. It freezes all counting when the processor halts, and exposes the counters through a single-outstanding request/acknowledge readout port. This makes cycle and instruction counts available on-chip without a bench.

## Interface
- CNT_W, 32, width of every counter and of rd_data (legal 8..64)
- clk  in  1  system clock; everything is on its rising edge
- rst  in  1  reset; synchronous, active-low (rst==0 at a rising edge resets the block)
- retire_regwrite  in  1  a register-file write commits this cycle
- retire_memwrite  in  1  a data-memory write commits this cycle
- halt  in  1  halt instruction is in memory/writeback this cycle
- icache_req / icache_hit  in  1 each  valid instruction-cache request / hit this cycle
- dcache_req / dcache_hit  in  1 each  valid data-cache request / hit this cycle
- clear  in  1  zero all counters and return to RUN
- rd_req  in  1  readout request, level, held until rd_ack seen
- rd_sel  in  3  counter index, sampled with rd_req
- rd_ack  out  1  one-cycle pulse, rd_data valid this cycle
- rd_data  out  CNT_W  selected counter snapshot, held until next ack
- halted  out  1  FSM is in HALTED

## Operation
- Counter map (rd_sel):
  - 0: cycles.
  - 1: instructions (halt | retire_regwrite | retire_memwrite, max +1 per cycle).
  - 2: icache_req.
  - 3: icache_hit.
  - 4: dcache_req.
  - 5: dcache_hit.
  - 6: cycle stamp at halt.
  - 7: protocol errors (cycles with icache_hit & !icache_req, or dcache_hit & !dcache_req; +1 per cycle even if both occur).
- Run/halt FSM, two states:
  - RUN: each edge, cycles +1 and each asserted event counter +1.
  - RUN -> HALTED on the edge where halt==1. That edge's events and cycle are still counted. Counter 6 loads the post-increment cycle value.
  - HALTED: no counter changes and all event inputs ignored; readout still works.
  - HALTED -> RUN only on clear.
- Saturation: every counter sticks at all-ones; no wrap.
- clear: on the edge where clear==1:
  - All counters 0 and state RUN.
  - Events on that same edge are discarded (clear wins over halt and over events).
  - A readout in progress is unaffected.
- Readout FSM:
  - States: R_IDLE, R_ACK, R_WAIT.
  - R_IDLE -> R_ACK when rd_req==1: latch rd_sel. rd_data loads the selected counter's next value (including that edge's increment or clear).
  - R_ACK: rd_ack=1 for exactly this cycle, then -> R_WAIT.
  - R_WAIT -> R_IDLE when rd_req==0. A held rd_req therefore yields exactly one ack.
- Reset (rst==0 at edge): all counters 0, state RUN, readout R_IDLE, rd_ack=0, rd_data=0, halted=0. Reset overrides clear, halt and rd_req.

## Timing
- Event sampled at edge N is visible in the counter register after edge N.
- Read latency: rd_req high at edge N -> rd_ack high during cycle N+1 -> back-to-back minimum spacing 3 cycles (ack, then rd_req low observed, then new request).
- rd_data changes only on the edge entering R_ACK or on reset.
- halted rises the cycle after the halt edge. A halt asserted for several cycles counts as one instruction only (later cycles are in HALTED).
- Reset deasserting mid-readout: the readout restarts in R_IDLE; a still-high rd_req is accepted on the first edge with rst==1.

## Test plan
- Reset, then 10 RUN cycles with retire_regwrite on 4 of them and retire_memwrite on 2 of them (none overlapping) -> read sel 0 = 10 and sel 1 = 6, each with a single 1-cycle rd_ack.
- Cycle with retire_regwrite=1 and retire_memwrite=1 together, then halt at cycle 20 -> instructions +1 for the dual cycle. Counter 6 = 20, halted=1 next cycle. Further events over 5 cycles leave all counters unchanged.
- CNT_W=8: hold icache_req for 300 cycles -> sel 2 reads 255.
- dcache_hit=1 with dcache_req=0 for 3 cycles, plus one cycle with both i and d violations -> sel 7 = 4.
- clear and halt asserted on the same edge while counters are nonzero -> all counters 0, halted=0, and counting resumes next cycle.
- rd_req held high for 6 cycles -> exactly one rd_ack. Drop rd_req, re-raise with sel 0 -> second ack with the updated count. rst=0 for one cycle between requests -> rd_data=0 and rd_ack=0.
